uart_tx: RTL and testbench

- Serial UART transmitter: 8N1 framing, LSB first, run-time configurable baud divisor.
- Pairs with the team's UART receiver, which uses the same DB divisor input.
- Has a one-byte holding register so the host can queue the next byte while a frame is on the wire. Back-to-back frames then go out with no idle gap.
- Sits between the host/command logic and the TX pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_if.sv | 17 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx.sv | 104 ++++++++++
 tb/tb_uart_tx.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching receiver.
// Define UART_TX_PARITY_EN to build 8E1 framing (11 bits) instead of 8N1.
package uart_pkg;

  typedef enum logic {IDLE, TXING} state_t;

  localparam int DATA_BITS    = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS   = 11;
`else
  localparam int FRAME_BITS   = 10;
`endif
  localparam int BIT_CNT_W    = 4;
  localparam int DB_W_DEFAULT = 13;

  // Wire order is LSB first: start bit in bit 0, stop bit on top.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_BITS-1:0] data);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^data, data, 1'b0};
`else
    return {1'b1, data, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake bundle of the UART transmitter.
// The master modport is the host; the slave modport is the transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DB_W = DB_W_DEFAULT
);
  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic [DB_W-1:0]      DB;
  logic                 TX;
  logic                 tx_done;
  logic                 hold_full;

  modport master (output trmt, tx_data, DB, input TX, tx_done, hold_full);
  modport slave  (input trmt, tx_data, DB, output TX, tx_done, hold_full);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses shift_o for one clock every db_i clocks while enabled.
// Shared with the UART receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DB_W = DB_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DB_W-1:0] db_i,
  input  logic            clear_i,
  input  logic            enable_i,
  output logic            shift_o
);

  logic [DB_W-1:0] baud_cnt_q;

  assign shift_o = enable_i && (baud_cnt_q == db_i - DB_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
    end else if (clear_i || shift_o) begin
      baud_cnt_q <= '0;
    end else if (enable_i) begin
      baud_cnt_q <= baud_cnt_q + DB_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, with a one-byte holding register for gapless frames.
// Framing is 8N1, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DB_W = DB_W_DEFAULT
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);

  state_t                state_q;
  logic [FRAME_BITS-1:0] shifter_q;
  logic [FRAME_BITS-1:0] shifter_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [DATA_BITS-1:0]  hold_q;
  logic                  hold_full_q;
  logic                  tx_done_q;
  logic [DB_W-1:0]       db_q;
  logic                  txing;
  logic                  shift;
  logic                  frame_end;
  logic                  frame_start;

  assign txing       = (state_q == TXING);
  assign shifter_d   = {1'b1, shifter_q[FRAME_BITS-1:1]};
  assign frame_end   = txing && shift && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
  assign frame_start = (!txing && bus.trmt) || (frame_end && (hold_full_q || bus.trmt));

  uart_baud_tick #(
    .DB_W(DB_W)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .db_i    (db_q),
    .clear_i (frame_start),
    .enable_i(txing),
    .shift_o (shift)
  );

  // The divisor is re-latched on every frame start so mid-frame DB changes wait for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shifter_q   <= '1;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_done_q   <= 1'b0;
      db_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.trmt) begin
            shifter_q <= frame_word(bus.tx_data);
            bit_cnt_q <= '0;
            db_q      <= bus.DB;
            tx_done_q <= 1'b0;
            state_q   <= TXING;
          end
        end
        TXING: begin
          if (frame_end) begin
            if (hold_full_q) begin
              shifter_q <= frame_word(hold_q);
              bit_cnt_q <= '0;
              db_q      <= bus.DB;
              if (bus.trmt) begin
                hold_q <= bus.tx_data;
              end else begin
                hold_full_q <= 1'b0;
              end
            end else if (bus.trmt) begin
              shifter_q <= frame_word(bus.tx_data);
              bit_cnt_q <= '0;
              db_q      <= bus.DB;
            end else begin
              shifter_q <= shifter_d;
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              tx_done_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else begin
            if (shift) begin
              shifter_q <= shifter_d;
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
            if (bus.trmt && !hold_full_q) begin
              hold_q      <= bus.tx_data;
              hold_full_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.TX        = shifter_q[0];
  assign bus.tx_done   = tx_done_q;
  assign bus.hold_full = hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx in its default 8N1 build
// (UART_TX_PARITY_EN undefined); all samples are taken on the falling clock edge.
module tb_uart_tx;

  localparam int DB_W = 13;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  uart_tx_if #(.DB_W(DB_W)) bus ();

  uart_tx #(.DB_W(DB_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level for bit slot idx of an 8N1 frame.
  function automatic logic expBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // Pulse trmt for one clock; returns on the falling edge just after the start edge.
  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    checkOutput("pre-start TX", 32'(bus.TX), 32'd1);
    bus.trmt    = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.trmt = 1'b0;
  endtask

  // Walks one frame sample by sample, optionally injecting two trmt pulses and a DB change.
  task automatic checkFrame(input string tag, input logic [7:0] d, input int db,
                            input int injN, input logic [7:0] injD,
                            input int inj2N, input logic [7:0] inj2D,
                            input int dbN, input logic [DB_W-1:0] dbVal,
                            input int holdStart);
    int holdExp;
    holdExp = holdStart;
    for (int n = 0; n < 10 * db; n++) begin
      if (injN >= 0 && n == injN + 1) holdExp = 1;
      checkOutput({tag, " TX"}, 32'(bus.TX), 32'(expBit(d, n / db)));
      checkOutput({tag, " tx_done"}, 32'(bus.tx_done), 32'd0);
      checkOutput({tag, " hold_full"}, 32'(bus.hold_full), 32'(holdExp));
      if (n == injN) begin
        bus.trmt    = 1'b1;
        bus.tx_data = injD;
      end
      if (n == inj2N) begin
        bus.trmt    = 1'b1;
        bus.tx_data = inj2D;
      end
      if (n == dbN) bus.DB = dbVal;
      @(negedge clk);
      bus.trmt = 1'b0;
    end
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      checkOutput({tag, " idle TX"}, 32'(bus.TX), 32'd1);
      checkOutput({tag, " idle tx_done"}, 32'(bus.tx_done), 32'd1);
      checkOutput({tag, " idle hold_full"}, 32'(bus.hold_full), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;
    bus.DB      = 13'd16;

    #12;
    checkOutput("reset TX", 32'(bus.TX), 32'd1);
    checkOutput("reset tx_done", 32'(bus.tx_done), 32'd0);
    checkOutput("reset hold_full", 32'(bus.hold_full), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset TX", 32'(bus.TX), 32'd1);

    $display("[TB] single frame 0xA5 at DB=16");
    applyStimulus(8'hA5);
    checkFrame("a5", 8'hA5, 16, -1, 8'h00, -1, 8'h00, -1, 13'd16, 0);
    checkIdle("a5", 20);

    $display("[TB] back-to-back 0x3C/0xC3 with dropped 0xFF");
    applyStimulus(8'h3C);
    checkFrame("b2b-1", 8'h3C, 16, 40, 8'hC3, 60, 8'hFF, -1, 13'd16, 0);
    checkFrame("b2b-2", 8'hC3, 16, -1, 8'h00, -1, 8'h00, -1, 13'd16, 0);
    checkIdle("b2b", 40);

    $display("[TB] trmt on frame-end shift at DB=20");
    bus.DB = 13'd20;
    applyStimulus(8'h33);
    checkFrame("gap-1", 8'h33, 20, 199, 8'hA6, -1, 8'h00, -1, 13'd20, 0);
    checkFrame("gap-2", 8'hA6, 20, -1, 8'h00, -1, 8'h00, -1, 13'd20, 0);
    checkIdle("gap", 30);

    $display("[TB] DB change mid-frame");
    bus.DB = 13'd16;
    applyStimulus(8'h96);
    checkFrame("db16", 8'h96, 16, -1, 8'h00, -1, 8'h00, 50, 13'd32, 0);
    checkIdle("db16", 10);
    applyStimulus(8'h0F);
    checkFrame("db32", 8'h0F, 32, -1, 8'h00, -1, 8'h00, -1, 13'd32, 0);
    checkIdle("db32", 10);

    $display("[TB] reset during bit 4");
    bus.DB = 13'd16;
    applyStimulus(8'h81);
    repeat (10) @(negedge clk);
    bus.trmt    = 1'b1;
    bus.tx_data = 8'h77;
    @(negedge clk);
    bus.trmt = 1'b0;
    checkOutput("abort hold_full before", 32'(bus.hold_full), 32'd1);
    repeat (59) @(negedge clk);
    checkOutput("abort bit4 TX", 32'(bus.TX), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort TX", 32'(bus.TX), 32'd1);
    checkOutput("abort hold_full", 32'(bus.hold_full), 32'd0);
    checkOutput("abort tx_done", 32'(bus.tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01);
    checkFrame("after-reset", 8'h01, 16, -1, 8'h00, -1, 8'h00, -1, 13'd16, 0);
    checkIdle("after-reset", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
